// File: rtl/cv32e40p_shadow_spill_if.sv
// OBI-style data write port used to spill shadow registers to the interrupt stack frame.
// The spill sequencer drives the master side; the data memory side is the slave.
interface cv32e40p_shadow_spill_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  data_req_o;
    logic                  data_gnt_i;
    logic [31:0]           data_addr_o;
    logic                  data_we_o;
    logic [3:0]            data_be_o;
    logic [DATA_WIDTH-1:0] data_wdata_o;
    logic                  data_rvalid_i;

    modport master (
        output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i
    );

    modport slave (
        input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i
    );
endinterface

// File: rtl/cv32e40p_shadow_spill.sv
// Spills captured caller-save shadow words to the interrupt stack frame at sp + 4*k.
// Optional macro CV32E40P_SHADOW_SPILL_PIPE_EN allows two outstanding stores instead of one.
module cv32e40p_shadow_spill #(
    parameter int NUM_WORDS_SHADOW = 16,
    parameter int ADDR_WIDTH       = 5,
    parameter int DATA_WIDTH       = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [DATA_WIDTH-1:0]   sp_i,
    output logic [ADDR_WIDTH-1:0]   shadow_raddr_o,
    input  logic [DATA_WIDTH-1:0]   shadow_rdata_i,
    cv32e40p_shadow_spill_if.master data,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int            KW     = $clog2(NUM_WORDS_SHADOW) + 1;
    localparam logic [KW-1:0] K_LAST = KW'(NUM_WORDS_SHADOW);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] base_q;
    logic [KW-1:0]         k_q;
    logic [1:0]            outst_q, outst_d;
    logic                  req;
    logic                  acc;
    logic                  rsp;

    assign acc = req & data.data_gnt_i;
    // A response with nothing outstanding is dropped so the counter never underflows.
    assign rsp = data.data_rvalid_i & (outst_q != 2'd0);

`ifdef CV32E40P_SHADOW_SPILL_PIPE_EN
    assign req = (state_q == REQ) && (k_q < K_LAST) && (outst_q != 2'd2);
`else
    assign req = (state_q == REQ);
`endif

    always_comb begin
        outst_d = outst_q;
        if (acc && !rsp) begin
            outst_d = outst_q + 2'd1;
        end else if (!acc && rsp) begin
            outst_d = outst_q - 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_i) state_d = REQ;
`ifdef CV32E40P_SHADOW_SPILL_PIPE_EN
            // Requests and responses overlap; finish once every word is issued and acknowledged.
            REQ:  if ((k_q == K_LAST) && (outst_d == 2'd0)) state_d = DONE;
            WAIT: state_d = REQ;
`else
            REQ:  if (acc) state_d = WAIT;
            WAIT: if (rsp) state_d = (k_q == K_LAST) ? DONE : REQ;
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            k_q     <= '0;
            outst_q <= 2'd0;
        end else begin
            state_q <= state_d;
            outst_q <= outst_d;
            if ((state_q == IDLE) && start_i) begin
                base_q <= sp_i;
                k_q    <= '0;
            end else if (acc) begin
                k_q <= k_q + KW'(1);
            end
        end
    end

    // Word k lands at base + 4*k so shadow word 0 (ra) sits at the lowest frame address.
    assign data.data_req_o   = req;
    assign data.data_we_o    = req;
    assign data.data_be_o    = {4{req}};
    assign data.data_addr_o  = req ? (base_q + {30'(k_q), 2'b00}) : '0;
    assign data.data_wdata_o = req ? shadow_rdata_i : '0;
    assign shadow_raddr_o    = req ? ADDR_WIDTH'(k_q) : '0;

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && data.data_rvalid_i) begin
            assert (outst_q != 2'd0);
        end
    end
`endif

endmodule

// File: tb/tb_cv32e40p_shadow_spill.sv
// Bench for cv32e40p_shadow_spill: standard-ABI and EABI instances checked every cycle against a frame-store model.
module tb_cv32e40p_shadow_spill;

`ifdef CV32E40P_SHADOW_SPILL_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif
    localparam int LIM = PIPE ? 2 : 1;

    logic        clk;
    logic        rst_n;
    logic        start  [2];
    logic [31:0] sp     [2];
    logic [4:0]  raddr  [2];
    logic [31:0] rdata  [2];
    logic        busy   [2];
    logic        done   [2];
    logic        req    [2];
    logic        gnt    [2];
    logic        rvalid [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic        we     [2];
    logic [3:0]  be     [2];

    cv32e40p_shadow_spill_if #(.DATA_WIDTH(32)) bus0 ();
    cv32e40p_shadow_spill_if #(.DATA_WIDTH(32)) bus1 ();

    cv32e40p_shadow_spill #(.NUM_WORDS_SHADOW(16), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start[0]), .sp_i(sp[0]),
        .shadow_raddr_o(raddr[0]), .shadow_rdata_i(rdata[0]), .data(bus0),
        .busy_o(busy[0]), .done_o(done[0])
    );

    cv32e40p_shadow_spill #(.NUM_WORDS_SHADOW(7), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start[1]), .sp_i(sp[1]),
        .shadow_raddr_o(raddr[1]), .shadow_rdata_i(rdata[1]), .data(bus1),
        .busy_o(busy[1]), .done_o(done[1])
    );

    assign bus0.data_gnt_i    = gnt[0];
    assign bus0.data_rvalid_i = rvalid[0];
    assign req[0]   = bus0.data_req_o;
    assign addr[0]  = bus0.data_addr_o;
    assign wdata[0] = bus0.data_wdata_o;
    assign we[0]    = bus0.data_we_o;
    assign be[0]    = bus0.data_be_o;

    assign bus1.data_gnt_i    = gnt[1];
    assign bus1.data_rvalid_i = rvalid[1];
    assign req[1]   = bus1.data_req_o;
    assign addr[1]  = bus1.data_addr_o;
    assign wdata[1] = bus1.data_wdata_o;
    assign we[1]    = bus1.data_we_o;
    assign be[1]    = bus1.data_be_o;

    // Shadow register file contents: word k holds 0x100 + k.
    assign rdata[0] = 32'h100 + 32'(raddr[0]);
    assign rdata[1] = 32'h100 + 32'(raddr[1]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_run;
    int n_fail;
    int cyc;

    // Model state: what the spill must look like in the current cycle.
    bit          act      [2];
    bit          exp_done [2];
    bit          pend_rv  [2];
    logic [31:0] base     [2];
    int          widx     [2];
    int          outst    [2];

    int          done_cyc  [2];
    int          stores    [2];
    int          w5_cycles [2];
    logic [31:0] last_addr [2];
    bit          pin5;

    int          s_start [2];
    int          s_pulse [2];
    logic [31:0] s_sp    [2];
    logic [31:0] s_psp   [2];
    int          hold_w  [2];
    int          hold_left [2];
    int          s_rst;

    function automatic int nw(input int u);
        return (u == 0) ? 16 : 7;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    task automatic check_unit(input int u);
        bit          er;
        logic [31:0] ea;
        er = act[u] && (widx[u] < nw(u)) && (outst[u] < LIM) && !exp_done[u];
        chk($sformatf("u%0d_req", u), 32'(req[u]), 32'(er));
        chk($sformatf("u%0d_busy", u), 32'(busy[u]), 32'(act[u]));
        chk($sformatf("u%0d_done", u), 32'(done[u]), 32'(exp_done[u]));
        if (done[u]) done_cyc[u] = cyc;
        if (req[u]) begin
            ea = base[u] + 32'(4 * widx[u]);
            chk($sformatf("u%0d_addr", u), addr[u], ea);
            chk($sformatf("u%0d_wdata", u), wdata[u], 32'h100 + 32'(widx[u]));
            chk($sformatf("u%0d_raddr", u), 32'(raddr[u]), 32'(widx[u]));
            chk($sformatf("u%0d_we_be", u), {27'd0, we[u], be[u]}, 32'h1F);
            if (widx[u] == 5) begin
                w5_cycles[u]++;
                if (pin5 && u == 0) begin
                    chk("w5_addr_pin", addr[u], 32'h0000_1FD4);
                    chk("w5_data_pin", wdata[u], 32'h0000_0105);
                end
            end
        end else begin
            chk($sformatf("u%0d_idle_bus", u),
                addr[u] | wdata[u] | 32'(raddr[u]) | 32'(be[u]) | 32'(we[u]), 32'h0);
        end
        chk($sformatf("u%0d_outst_max", u), 32'(outst[u] <= LIM), 32'h1);
    endtask

    task automatic step();
        bit acc;
        bit nd;
        @(negedge clk);
        cyc++;
        for (int u = 0; u < 2; u++) check_unit(u);
        rst_n = !((cyc <= 2) || (cyc == s_rst));
        for (int u = 0; u < 2; u++) begin
            start[u]  = (cyc == s_start[u]) || (cyc == s_pulse[u]);
            sp[u]     = (cyc == s_pulse[u]) ? s_psp[u] : s_sp[u];
            gnt[u]    = 1'b1;
            if (!rst_n) begin
                gnt[u] = 1'b0;
            end else if (req[u] && (widx[u] == hold_w[u]) && (hold_left[u] > 0)) begin
                gnt[u] = 1'b0;
                hold_left[u]--;
            end
            rvalid[u] = pend_rv[u];

            acc = req[u] && gnt[u];
            if (!rst_n) begin
                act[u] = 1'b0; exp_done[u] = 1'b0; pend_rv[u] = 1'b0;
                outst[u] = 0; widx[u] = 0;
            end else begin
                nd = 1'b0;
                if (acc) begin
                    widx[u]++;
                    outst[u]++;
                    stores[u]++;
                    last_addr[u] = addr[u];
                end
                pend_rv[u] = acc;
                if (rvalid[u]) begin
                    outst[u]--;
                    if ((widx[u] == nw(u)) && (outst[u] == 0)) nd = 1'b1;
                end
                if (exp_done[u]) begin
                    act[u] = 1'b0;
                end else if (!act[u] && start[u]) begin
                    act[u] = 1'b1; base[u] = sp[u]; widx[u] = 0; outst[u] = 0;
                end
                exp_done[u] = nd;
            end
        end
    endtask

    task automatic run(input int u, input logic [31:0] spv, input int hw, input int pulse_off,
                       input int rst_off, input int exp_len);
        int t;
        t = cyc + 1;
        s_start[u]   = t;
        s_sp[u]      = spv;
        s_pulse[u]   = (pulse_off >= 0) ? t + pulse_off : -1;
        s_psp[u]     = 32'h0000_3000;
        s_rst        = (rst_off >= 0) ? t + rst_off : -1;
        hold_w[u]    = hw;
        hold_left[u] = 3;
        done_cyc[u]  = -1;
        stores[u]    = 0;
        w5_cycles[u] = 0;
        for (int i = 0; i < 120; i++) begin
            step();
            if ((rst_off >= 0) && (cyc == t + rst_off + 2)) break;
            if (done_cyc[u] >= 0) break;
        end
        if (rst_off < 0) begin
            chk($sformatf("u%0d_done_time", u), 32'(done_cyc[u] - t), 32'(exp_len));
            chk($sformatf("u%0d_store_count", u), 32'(stores[u]), 32'(nw(u)));
        end else begin
            chk("rst_no_done", 32'(done_cyc[u] >= 0), 32'h0);
            chk("rst_busy_low", 32'(busy[u]), 32'h0);
        end
    endtask

    initial begin
        n_run = 0; n_fail = 0; cyc = 0; pin5 = 1'b0; s_rst = -1;
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0; sp[u] = '0; gnt[u] = 1'b0; rvalid[u] = 1'b0;
            act[u] = 1'b0; exp_done[u] = 1'b0; pend_rv[u] = 1'b0; base[u] = '0;
            widx[u] = 0; outst[u] = 0; done_cyc[u] = -1; stores[u] = 0; w5_cycles[u] = 0;
            last_addr[u] = '0; s_start[u] = -1; s_pulse[u] = -1; s_sp[u] = '0; s_psp[u] = '0;
            hold_w[u] = -1; hold_left[u] = 0;
        end
        for (int i = 0; i < 4; i++) step();

        run(0, 32'h0000_1FC0, -1, -1, -1, PIPE ? 18 : 33);
        chk("std_last_addr", last_addr[0], 32'h0000_1FFC);

        pin5 = 1'b1;
        run(0, 32'h0000_1FC0, 5, -1, -1, PIPE ? 21 : 36);
        pin5 = 1'b0;
        chk("w5_req_cycles", 32'(w5_cycles[0]), 32'd4);

        run(0, 32'h0000_1FC0, -1, 10, -1, PIPE ? 18 : 33);
        chk("repulse_last_addr", last_addr[0], 32'h0000_1FFC);

        run(1, 32'hFFFF_FFF8, -1, -1, -1, PIPE ? 9 : 15);
        chk("eabi_last_addr", last_addr[1], 32'h0000_0010);

        run(0, 32'h0000_1FC0, -1, -1, 8, 0);
        run(0, 32'h0000_2000, -1, -1, -1, PIPE ? 18 : 33);
        chk("restart_last_addr", last_addr[0], 32'h0000_203C);

        step();
        step();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
